ivl_uvm_ovl_fire_collector: RTL and testbench
=============================================

# ivl_uvm_ovl_fire_collector

Downstream consumer for the OVL checkers (ovl_window and siblings) in the ivl_uvm assertion benches. It samples the single-cycle fire pulses of up to NUM_CHK checkers, keeps a saturating fire count per checker, and latches the index and cycle stamp of the first failure. It also raises a sticky error flag. Bench code reads per-checker counts through a four-phase request/acknowledge port, so pass/fail is decided from one place instead of per-checker $monitor output.

## Interface
- NUM_CHK, 4: number of checker fire inputs (1..16).
- CNT_W, 8: width of each per-checker fire counter.
- TS_W, 32: width of the free-running cycle stamp.
- IDX_W, $clog2(NUM_CHK) (min 1): checker index width.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sampling clock, shared with the checkers.
- reset  in  1  synchronous active-high reset.
- enable  in  1  when 0, fire inputs are ignored and the cycle stamp holds.
- fire  in  NUM_CHK  bit i = fire output bit 0 of checker i, one pulse per violation.
- clear  in  1  synchronous clear of all statistics.
- rd_req  in  1  read request, four-phase.
- rd_idx  in  IDX_W  checker to read; must be stable while rd_req=1.
- rd_ack  out  1  read acknowledge.
- rd_count  out  CNT_W  fire count of checker rd_idx, valid while rd_ack=1.
- any_fire  out  1  sticky: at least one fire since reset/clear.
- first_valid  out  1  first_idx/first_ts hold a capture.
- first_idx  out  IDX_W  index of the first checker to fire.
- first_ts  out  TS_W  cycle stamp of the first fire.
- cycle_cnt  out  TS_W  free-running cycle stamp.

## Operation
- Cycle stamp:
  - cycle_cnt increments by 1 each clock with enable=1.
  - It wraps from 2^TS_W-1 to 0.
- Fire counting:
  - Each cycle with enable=1, every counter i with fire[i]=1 increments by 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- any_fire is set on any counted fire. Only reset or clear lower it.
- First-fire capture:
  - Armed while first_valid=0.
  - On the first cycle with a counted fire, it stores first_idx = lowest set index in fire, stores first_ts = cycle_cnt value of that cycle, and sets first_valid=1.
  - Later fires never overwrite the capture.
- Clear:
  - Zeroes all counters, any_fire, first_valid, first_idx, first_ts and cycle_cnt.
  - Clear has priority over same-cycle fires, which are discarded.
  - Clear does not disturb the read handshake.
- Read FSM: states IDLE, CAPTURE, ACK.
  - IDLE: rd_req=1 -> CAPTURE.
  - CAPTURE: rd_count loads the counter[rd_idx] value held in registers at that cycle, i.e. before that cycle's update. rd_idx >= NUM_CHK loads 0. -> ACK.
  - ACK: rd_ack=1 and rd_count held. rd_req=0 -> IDLE with rd_ack=0.
- Fires continue to count during a read; only the snapshot is frozen.

## Timing
- Reset values: rd_ack=0, rd_count=0, any_fire=0, first_valid=0, first_idx=0, first_ts=0, cycle_cnt=0, all counters 0, FSM=IDLE.
- Fire-to-output latency: fire sampled at edge N gives count/any_fire/first_* visible after edge N, i.e. 1 cycle.
- Read latency:
  - rd_req first seen high at edge N -> CAPTURE at N+1 -> rd_ack=1 after edge N+2.
  - rd_req seen low in ACK at edge M -> rd_ack=0 after edge M.
  - A new request is accepted no earlier than edge M+1.
- Reset mid-read: FSM to IDLE and rd_ack=0 on the next edge, whatever rd_req is.
- enable=0: fires and cycle_cnt are frozen. Clear and reads still work.
- Simultaneous fires on several checkers:
  - Every set bit is counted.
  - first_idx is the lowest set index.

## Test plan
- Reset then idle 10 cycles, no fires -> any_fire=0, first_valid=0, cycle_cnt=10 (stamp starts at 0 on the first clock after reset deasserts).
- fire=4'b0100 pulsed at stamp 5, then 4'b0001 at stamp 9 -> first_idx=2, first_ts=5; read idx 0 -> 1; read idx 2 -> 1; any_fire=1.
- fire=4'b1010 in one cycle -> first_idx=1; counts for idx 1 and idx 3 both 1.
- CNT_W=8 with fire[0] held high for 300 enabled cycles -> read idx 0 returns 255.
- rd_req raised with rd_idx=3 while fire[3] pulses every cycle:
  - rd_ack rises exactly 2 cycles after rd_req.
  - rd_count equals the count before the capture-cycle fire and holds until rd_req drops.
  - rd_ack falls 1 cycle after rd_req drops.
- Clear asserted in the same cycle as fire=4'b0001, and reset asserted during ACK:
  - Clear: all statistics 0, first_valid=0.
  - Reset: rd_ack=0 next cycle, FSM back to IDLE.

Source files
------------

// File: rtl/ivl_uvm_ovl_fire_collector.sv
// ---------------------------------------------------------------------------
// ivl_uvm_ovl_fire_collector
//
// Collects the single-cycle fire pulses of up to NUM_CHK OVL checkers.
// It keeps one saturating fire counter per checker and a sticky any-fire
// flag. It also captures the index and cycle stamp of the first failure.
// Per-checker counts are read through a four-phase req/ack port.
//
// Ports:
//   clock        sampling clock shared with the checkers
//   reset        synchronous active-high reset
//   enable       0 = ignore fires and hold the cycle stamp
//   fire         one bit per checker, one pulse per violation
//   clear        synchronous clear of all statistics (not the read port)
//   rd_req       four-phase read request
//   rd_idx       checker to read, stable while rd_req=1
//   rd_ack       read acknowledge
//   rd_count     snapshot of counter[rd_idx], valid while rd_ack=1
//   any_fire     sticky: at least one counted fire since reset/clear
//   first_valid  first_idx/first_ts hold a capture
//   first_idx    lowest index firing in the first counted fire cycle
//   first_ts     cycle stamp of that first fire
//   cycle_cnt    free-running (enable-gated) cycle stamp
// ---------------------------------------------------------------------------
module ivl_uvm_ovl_fire_collector #(
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 32,
  parameter int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_CHK-1:0] fire,
  input  logic               clear,
  input  logic               rd_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_ack,
  output logic [CNT_W-1:0]   rd_count,
  output logic               any_fire,
  output logic               first_valid,
  output logic [IDX_W-1:0]   first_idx,
  output logic [TS_W-1:0]    first_ts,
  output logic [TS_W-1:0]    cycle_cnt
);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} rd_state_t;

  rd_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt [NUM_CHK];
  logic               counted;
  logic [IDX_W-1:0]   low_idx;
  logic [CNT_W-1:0]   rd_sel;

  // Saturating increment: an all-ones counter stays put.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A fire only counts when enabled and not discarded by a same-cycle clear.
  always_comb begin
    counted = enable && !clear && (|fire);
    low_idx = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (fire[i]) low_idx = IDX_W'(i);
    end
  end

  // Indices with no counter behind them read as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (rd_idx == IDX_W'(i)) rd_sel = cnt[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_CHK; i++) cnt[i] <= '0;
      cycle_cnt   <= '0;
      any_fire    <= 1'b0;
      first_valid <= 1'b0;
      first_idx   <= '0;
      first_ts    <= '0;
    end else if (enable) begin
      for (int i = 0; i < NUM_CHK; i++) begin
        if (fire[i]) cnt[i] <= sat_inc(cnt[i]);
      end
      cycle_cnt <= cycle_cnt + TS_W'(1);
      if (counted) any_fire <= 1'b1;
      if (counted && !first_valid) begin
        first_valid <= 1'b1;
        first_idx   <= low_idx;
        first_ts    <= cycle_cnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_req) state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     if (!rd_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The snapshot is taken from the pre-update counter value in CAPTURE.
  // The ack is registered one edge after ACK is entered. It drops on the
  // same edge that sees rd_req low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rd_ack   <= 1'b0;
      rd_count <= '0;
    end else begin
      state  <= state_nxt;
      rd_ack <= (state == ACK) && rd_req;
      if (state == CAPTURE) rd_count <= rd_sel;
    end
  end

endmodule

// File: tb/tb_ivl_uvm_ovl_fire_collector.sv
module tb_ivl_uvm_ovl_fire_collector;

  localparam int NUM_CHK = 4;
  localparam int CNT_W   = 8;
  localparam int TS_W    = 32;
  localparam int IDX_W   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [NUM_CHK-1:0] fire;
  logic               clear;
  logic               rd_req;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_ack;
  logic [CNT_W-1:0]   rd_count;
  logic               any_fire;
  logic               first_valid;
  logic [IDX_W-1:0]   first_idx;
  logic [TS_W-1:0]    first_ts;
  logic [TS_W-1:0]    cycle_cnt;

  int total = 0;
  int bad   = 0;
  int model_cnt [NUM_CHK];
  int exp_q [$];

  ivl_uvm_ovl_fire_collector #(
    .NUM_CHK(NUM_CHK), .CNT_W(CNT_W), .TS_W(TS_W), .IDX_W(IDX_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .fire(fire),
    .clear(clear), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
    .rd_count(rd_count), .any_fire(any_fire), .first_valid(first_valid),
    .first_idx(first_idx), .first_ts(first_ts), .cycle_cnt(cycle_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; the count model follows the inputs sampled at that edge.
  task automatic step();
    @(posedge clock);
    if (reset || clear) begin
      for (int i = 0; i < NUM_CHK; i++) model_cnt[i] = 0;
    end else if (enable) begin
      for (int i = 0; i < NUM_CHK; i++)
        if (fire[i] && model_cnt[i] < 255) model_cnt[i]++;
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Full four-phase read; expected count is queued when the request starts.
  task automatic do_read(input int idx, input string tag);
    int n;
    int e;
    rd_idx = IDX_W'(idx);
    rd_req = 1'b1;
    exp_q.push_back(model_cnt[idx]);
    n = 0;
    while (!rd_ack && n < 8) begin
      step();
      n++;
    end
    // n edges including the sampling edge: ack follows two edges after it
    chk({tag, "_lat"}, n - 1, 2);
    e = exp_q.pop_front();
    chk(tag, rd_count, e);
    rd_req = 1'b0;
    step();
    chk({tag, "_ackfall"}, rd_ack, 0);
  endtask

  initial begin
    for (int i = 0; i < NUM_CHK; i++) model_cnt[i] = 0;
    reset = 1'b1; enable = 1'b0; fire = '0; clear = 1'b0;
    rd_req = 1'b0; rd_idx = '0;
    steps(2);
    chk("rst_ack", rd_ack, 0);
    chk("rst_count", rd_count, 0);
    chk("rst_any", any_fire, 0);
    chk("rst_fv", first_valid, 0);
    chk("rst_fidx", first_idx, 0);
    chk("rst_fts", first_ts, 0);
    chk("rst_cyc", cycle_cnt, 0);

    // Idle after reset
    reset = 1'b0; enable = 1'b1;
    steps(10);
    chk("idle_cyc", cycle_cnt, 10);
    chk("idle_any", any_fire, 0);
    chk("idle_fv", first_valid, 0);

    // First fire at stamp 5 (idx 2), later fire at stamp 9 (idx 0)
    clear = 1'b1; step(); clear = 1'b0;
    steps(5);
    chk("pre_cyc5", cycle_cnt, 5);
    fire = 4'b0100; step(); fire = '0;
    steps(3);
    fire = 4'b0001; step(); fire = '0;
    chk("ff_idx", first_idx, 2);
    chk("ff_ts", first_ts, 5);
    chk("ff_fv", first_valid, 1);
    chk("ff_any", any_fire, 1);
    do_read(0, "rd_i0");
    do_read(2, "rd_i2");

    // Simultaneous fires
    clear = 1'b1; step(); clear = 1'b0;
    fire = 4'b1010; step(); fire = '0;
    chk("sim_idx", first_idx, 1);
    chk("sim_ts", first_ts, 0);
    do_read(1, "sim_i1");
    do_read(3, "sim_i3");

    // enable=0 freezes fires and stamp; reads still work
    clear = 1'b1; step(); clear = 1'b0;
    enable = 1'b0; fire = 4'b1111;
    steps(3);
    chk("dis_cyc", cycle_cnt, 0);
    chk("dis_any", any_fire, 0);
    fire = '0;
    do_read(2, "dis_rd");
    enable = 1'b1;

    // Saturation
    clear = 1'b1; step(); clear = 1'b0;
    fire = 4'b0001; steps(300); fire = '0;
    chk("sat_model", model_cnt[0], 255);
    do_read(0, "sat_i0");
    do_read(1, "sat_i1");

    // Read while fire[3] pulses every cycle
    clear = 1'b1; step(); clear = 1'b0;
    fire = 4'b1000; steps(3);
    rd_idx = 2'd3; rd_req = 1'b1;
    step();                           // sampling edge -> CAPTURE
    exp_q.push_back(model_cnt[3]);    // pre-update value at the capture edge
    chk("live_ack0", rd_ack, 0);
    step();                           // capture edge
    chk("live_ack1", rd_ack, 0);
    step();
    chk("live_ack2", rd_ack, 1);
    chk("live_cnt", rd_count, exp_q.pop_front());
    chk("live_exp4", model_cnt[3], 6);
    steps(2);
    chk("live_hold_ack", rd_ack, 1);
    chk("live_hold_cnt", rd_count, 4);
    rd_req = 1'b0; step();
    chk("live_ackfall", rd_ack, 0);
    fire = '0;
    do_read(3, "live_final");

    // Clear beats a same-cycle fire
    clear = 1'b1; fire = 4'b0001; step(); clear = 1'b0; fire = '0;
    chk("clr_any", any_fire, 0);
    chk("clr_fv", first_valid, 0);
    chk("clr_fidx", first_idx, 0);
    chk("clr_fts", first_ts, 0);
    chk("clr_cyc", cycle_cnt, 0);
    do_read(0, "clr_i0");

    // Reset during ACK
    fire = 4'b0010; step(); fire = '0;
    rd_idx = 2'd1; rd_req = 1'b1;
    steps(3);
    chk("ra_ack", rd_ack, 1);
    chk("ra_cnt", rd_count, 1);
    reset = 1'b1; step();
    chk("ra_rst_ack", rd_ack, 0);
    chk("ra_rst_cnt", rd_count, 0);
    reset = 1'b0; rd_req = 1'b0; step();
    chk("ra_idle_ack", rd_ack, 0);
    do_read(1, "ra_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
